// File: rtl/generic_memory_dift_pkg.sv
// Shared types and constants for the generic_memory_dift controller slice.
package generic_memory_dift_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    SCRUB = 2'd1,
    SERVE = 2'd2
  } dift_ctrl_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with a combinational grant and a registered
// priority pointer that flips to the other requester after every grant.
module rr_arbiter_2
  import generic_memory_dift_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  // rr = 0 favours requester 0 on contention, rr = 1 favours requester 1
  logic rr;

  // Grant a lone requester directly; break ties with the pointer
  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) begin
        gnt = rr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // After a grant to p the pointer moves to 1-p
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (|gnt) begin
      rr <= gnt[0];
    end
  end

endmodule

// File: rtl/generic_memory_dift_ctrl.sv
// Front-end controller for a single-port data+tag SRAM: scrubs the array
// after reset, then shares it between two requesters with round-robin
// arbitration and a one-cycle grant-to-rvalid response.
module generic_memory_dift_ctrl
  import generic_memory_dift_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int TAG_WIDTH  = BE_WIDTH,
  parameter bit SCRUB_EN   = 1'b1
)(
  input  logic                                CLK,
  input  logic                                RSTN,
  input  logic [NUM_REQ-1:0]                  REQ_I,
  input  logic [NUM_REQ-1:0]                  WE_I,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  ADDR_I,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  WDATA_I,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]   WTAG_I,
  input  logic [NUM_REQ-1:0][BE_WIDTH-1:0]    BE_I,
  output logic [NUM_REQ-1:0]                  GNT_O,
  output logic [NUM_REQ-1:0]                  RVALID_O,
  output logic [DATA_WIDTH-1:0]               RDATA_O,
  output logic [TAG_WIDTH-1:0]                RTAG_O,
  output logic                                BUSY_O,
  output logic                                MEM_INITN_O,
  output logic                                MEM_CEN_O,
  output logic                                MEM_WEN_O,
  output logic [ADDR_WIDTH-1:0]               MEM_A_O,
  output logic [DATA_WIDTH-1:0]               MEM_D_O,
  output logic [TAG_WIDTH-1:0]                MEM_DTAG_O,
  output logic [BE_WIDTH-1:0]                 MEM_BEN_O,
  input  logic [DATA_WIDTH-1:0]               MEM_Q_I,
  input  logic [TAG_WIDTH-1:0]                MEM_QTAG_I
);

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  dift_ctrl_state_e        state;
  logic [ADDR_WIDTH-1:0]   scrub_cnt;
  logic                    initn;
  logic                    serve;
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      rvalid;
  logic                    win;

  logic                    mem_cen;
  logic                    mem_wen;
  logic [ADDR_WIDTH-1:0]   mem_a;
  logic [DATA_WIDTH-1:0]   mem_d;
  logic [TAG_WIDTH-1:0]    mem_dtag;
  logic [BE_WIDTH-1:0]     mem_ben;

  assign serve = (state == SERVE);

  // Requests are only arbitrated once the scrub is finished
  rr_arbiter_2 u_arb (
    .clk   (CLK),
    .rst_n (RSTN),
    .en    (serve),
    .req   (REQ_I),
    .gnt   (gnt)
  );

  // Grant is one-hot, so bit 1 alone identifies the winner
  assign win = gnt[1];

  // Sequencer: INIT for one cycle, optional full-array scrub, then serve forever
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= INIT;
      scrub_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          scrub_cnt <= '0;
          state     <= SCRUB_EN ? SCRUB : SERVE;
        end
        SCRUB: begin
          scrub_cnt <= scrub_cnt + CNT_ONE;
          if (scrub_cnt == CNT_LAST) begin
            state <= SERVE;
          end
        end
        SERVE: begin
          state <= SERVE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Memory INITN is released on the first clock edge after reset deasserts
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      initn <= 1'b0;
    end else begin
      initn <= 1'b1;
    end
  end

  // Each grant answers with exactly one rvalid pulse one cycle later
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rvalid <= '0;
    end else begin
      rvalid <= gnt;
    end
  end

  // Memory port mux: scrub writes zeros, otherwise the winner drives the port
  always_comb begin
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_ben  = '1;
    mem_a    = '0;
    mem_d    = '0;
    mem_dtag = '0;
    if (state == SCRUB) begin
      mem_cen = 1'b0;
      mem_wen = 1'b0;
      mem_ben = '0;
      mem_a   = scrub_cnt;
    end else if (|gnt) begin
      mem_cen  = 1'b0;
      mem_wen  = ~WE_I[win];
      mem_a    = ADDR_I[win];
      mem_d    = WDATA_I[win];
      mem_dtag = WTAG_I[win];
      mem_ben  = ~BE_I[win];
    end
  end

  assign GNT_O       = gnt;
  assign RVALID_O    = rvalid;
  assign RDATA_O     = MEM_Q_I;
  assign RTAG_O      = MEM_QTAG_I;
  assign BUSY_O      = ~serve;
  assign MEM_INITN_O = initn;
  assign MEM_CEN_O   = mem_cen;
  assign MEM_WEN_O   = mem_wen;
  assign MEM_A_O     = mem_a;
  assign MEM_D_O     = mem_d;
  assign MEM_DTAG_O  = mem_dtag;
  assign MEM_BEN_O   = mem_ben;

endmodule

// File: tb/tb_generic_memory_dift_ctrl.sv
// Scoreboard bench for generic_memory_dift_ctrl with a behavioural data+tag
// SRAM attached and a reference model of memory contents and arbitration.
module tb_generic_memory_dift_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TW = 4;
  localparam int DEPTH = 16;

  logic               CLK = 1'b0;
  logic               RSTN;
  logic [1:0]         REQ_I, WE_I;
  logic [1:0][AW-1:0] ADDR_I;
  logic [1:0][DW-1:0] WDATA_I;
  logic [1:0][TW-1:0] WTAG_I;
  logic [1:0][BW-1:0] BE_I;
  logic [1:0]         GNT_O, RVALID_O;
  logic [DW-1:0]      RDATA_O;
  logic [TW-1:0]      RTAG_O;
  logic               BUSY_O, MEM_INITN_O, MEM_CEN_O, MEM_WEN_O;
  logic [AW-1:0]      MEM_A_O;
  logic [DW-1:0]      MEM_D_O;
  logic [TW-1:0]      MEM_DTAG_O;
  logic [BW-1:0]      MEM_BEN_O;
  logic [DW-1:0]      MEM_Q_I;
  logic [TW-1:0]      MEM_QTAG_I;

  generic_memory_dift_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
                             .TAG_WIDTH(TW), .SCRUB_EN(1'b1)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ_I(REQ_I), .WE_I(WE_I), .ADDR_I(ADDR_I),
    .WDATA_I(WDATA_I), .WTAG_I(WTAG_I), .BE_I(BE_I), .GNT_O(GNT_O),
    .RVALID_O(RVALID_O), .RDATA_O(RDATA_O), .RTAG_O(RTAG_O), .BUSY_O(BUSY_O),
    .MEM_INITN_O(MEM_INITN_O), .MEM_CEN_O(MEM_CEN_O), .MEM_WEN_O(MEM_WEN_O),
    .MEM_A_O(MEM_A_O), .MEM_D_O(MEM_D_O), .MEM_DTAG_O(MEM_DTAG_O),
    .MEM_BEN_O(MEM_BEN_O), .MEM_Q_I(MEM_Q_I), .MEM_QTAG_I(MEM_QTAG_I)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port SRAM: byte-masked writes with per-byte tags, Q held on writes
  logic [DW-1:0] sram_d [DEPTH];
  logic [TW-1:0] sram_t [DEPTH];
  logic          preload = 1'b0;
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) begin
        sram_d[i] <= 32'hFFFF_FFFF;
        sram_t[i] <= 4'hF;
      end
    end else if (MEM_INITN_O && !MEM_CEN_O) begin
      if (!MEM_WEN_O) begin
        for (int b = 0; b < BW; b++) begin
          if (!MEM_BEN_O[b]) begin
            sram_d[MEM_A_O][8*b +: 8] <= MEM_D_O[8*b +: 8];
            sram_t[MEM_A_O][b]        <= MEM_DTAG_O[b];
          end
        end
      end else begin
        MEM_Q_I    <= sram_d[MEM_A_O];
        MEM_QTAG_I <= sram_t[MEM_A_O];
      end
    end
  end

  // Reference model state
  typedef struct {
    int          port;
    bit          rd;
    logic [31:0] d;
    logic [3:0]  t;
    int          edge_n;
  } exp_t;

  exp_t          sbq[$];
  logic [31:0]   ref_d [DEPTH];
  logic [3:0]    ref_t [DEPTH];
  int            last_win;
  int            edge_n = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one expectation per rvalid pulse and compare
  initial begin
    forever begin
      @(posedge CLK);
      edge_n++;
      #2;
      if (RSTN) begin
        check("gnt_onehot_or_zero", 32'(GNT_O == 2'b11), 32'd0);
        for (int p = 0; p < 2; p++) begin
          if (RVALID_O[p]) begin
            if (sbq.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_rvalid: port %0d pulsed with nothing outstanding", p);
            end else begin
              exp_t e;
              e = sbq.pop_front();
              check("rvalid_port", 32'(p), 32'(e.port));
              check("rvalid_latency", 32'(edge_n), 32'(e.edge_n + 1));
              if (e.rd) begin
                check("rdata", RDATA_O, e.d);
                check("rtag", 32'(RTAG_O), 32'(e.t));
              end
            end
          end
        end
        while (sbq.size() > 0 && sbq[0].edge_n + 1 <= edge_n) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_rvalid: port %0d got no response, expected 1", sbq[0].port);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic idle_inputs();
    REQ_I = '0; WE_I = '0; ADDR_I = '0; WDATA_I = '0; WTAG_I = '0; BE_I = '0;
  endtask

  // Reset, check reset values, then step through INIT and the scrub
  task automatic do_reset(input bit hold1, input logic [3:0] a1);
    RSTN = 1'b0;
    sbq.delete();
    idle_inputs();
    if (hold1) begin
      REQ_I[1] = 1'b1; WE_I[1] = 1'b0; ADDR_I[1] = a1;
    end
    repeat (2) @(negedge CLK);
    check("rst_gnt", 32'(GNT_O), 32'd0);
    check("rst_rvalid", 32'(RVALID_O), 32'd0);
    check("rst_busy", 32'(BUSY_O), 32'd1);
    check("rst_initn", 32'(MEM_INITN_O), 32'd0);
    check("rst_cen_wen", 32'({MEM_CEN_O, MEM_WEN_O}), 32'd3);
    check("rst_ben", 32'(MEM_BEN_O), 32'hF);
    check("rst_addr", 32'(MEM_A_O), 32'd0);
    check("rst_d", MEM_D_O, 32'd0);
    check("rst_dtag", 32'(MEM_DTAG_O), 32'd0);
    RSTN = 1'b1;
    for (int c = 0; c < 17; c++) begin
      #1;
      check("busy_during_scrub", 32'(BUSY_O), 32'd1);
      check("gnt_during_scrub", 32'(GNT_O), 32'd0);
      if (c == 0) begin
        check("init_cen", 32'(MEM_CEN_O), 32'd1);
      end else begin
        check("scrub_addr", 32'(MEM_A_O), 32'(c - 1));
        check("scrub_cen_wen_ben", 32'({MEM_CEN_O, MEM_WEN_O, MEM_BEN_O}), 32'd0);
        check("scrub_initn", 32'(MEM_INITN_O), 32'd1);
      end
      @(negedge CLK);
    end
    #1;
    check("busy_after_scrub", 32'(BUSY_O), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      ref_d[i] = '0;
      ref_t[i] = '0;
    end
    last_win = 1;
    #1;
  endtask

  // One SERVE cycle: drive at the falling edge, predict and check the grant
  task automatic cycle(input logic [1:0] req, input logic [1:0] we,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] t0, input logic [3:0] t1,
                       input logic [3:0] be0, input logic [3:0] be1);
    int p;
    exp_t e;
    logic [3:0]  a, t, be;
    logic [31:0] d;
    REQ_I = req; WE_I = we;
    ADDR_I[0] = a0; ADDR_I[1] = a1; WDATA_I[0] = d0; WDATA_I[1] = d1;
    WTAG_I[0] = t0; WTAG_I[1] = t1; BE_I[0] = be0; BE_I[1] = be1;
    #1;
    p = -1;
    if (req == 2'b11) p = (last_win == 0) ? 1 : 0;
    else if (req[0]) p = 0;
    else if (req[1]) p = 1;
    check("gnt", 32'(GNT_O), (p < 0) ? 32'd0 : (32'd1 << p));
    check("mem_cen", 32'(MEM_CEN_O), (p < 0) ? 32'd1 : 32'd0);
    if (p >= 0) begin
      a  = (p == 0) ? a0 : a1;
      d  = (p == 0) ? d0 : d1;
      t  = (p == 0) ? t0 : t1;
      be = (p == 0) ? be0 : be1;
      e.port = p;
      e.rd = !we[p];
      e.d = ref_d[a];
      e.t = ref_t[a];
      e.edge_n = edge_n;
      sbq.push_back(e);
      if (we[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            ref_d[a][8*b +: 8] = d[8*b +: 8];
            ref_t[a][b] = t[b];
          end
        end
      end
      last_win = p;
    end
    @(negedge CLK);
  endtask

  task automatic single(input int port, input bit we, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] t, input logic [3:0] be);
    if (port == 0) cycle(2'b01, {1'b0, we}, a, 4'd0, d, 32'd0, t, 4'd0, be, 4'd0);
    else           cycle(2'b10, {we, 1'b0}, 4'd0, a, 32'd0, d, 4'd0, t, 4'd0, be);
  endtask

  task automatic idle_cycle();
    cycle(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  // Hard stop if something hangs
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0;
    idle_inputs();
    preload = 1'b1;
    @(negedge CLK);
    preload = 1'b0;

    // Scrub clears the preloaded all-ones contents
    do_reset(1'b0, 4'd0);
    for (int a = 0; a < DEPTH; a++) single(0, 1'b0, 4'(a), 32'd0, 4'd0, 4'd0);
    idle_cycle();

    // Full write, byte-masked write, empty-mask write, each read back
    single(0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hA, 4'hF);
    single(0, 1'b0, 4'd3, 32'd0, 4'd0, 4'd0);
    single(0, 1'b1, 4'd3, 32'h11223344, 4'h5, 4'h2);
    single(0, 1'b0, 4'd3, 32'd0, 4'd0, 4'd0);
    single(1, 1'b1, 4'd3, 32'h55555555, 4'h7, 4'h0);
    single(1, 1'b0, 4'd3, 32'd0, 4'd0, 4'd0);
    single(1, 1'b1, 4'd9, 32'hCAFEF00D, 4'h3, 4'hF);
    single(1, 1'b0, 4'd9, 32'd0, 4'd0, 4'd0);
    idle_cycle();

    // Contention: port 0 reads A=1, port 1 writes A=2
    for (int i = 0; i < 6; i++)
      cycle(2'b11, 2'b10, 4'd1, 4'd2, 32'd0, 32'h1000 + 32'(i), 4'd0, 4'(i), 4'd0, 4'hF);
    single(0, 1'b0, 4'd2, 32'd0, 4'd0, 4'd0);

    // Randomized traffic, including withdrawn requests
    for (int i = 0; i < 250; i++)
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle_cycle();

    // Reset asserted while a read grant is outstanding
    REQ_I = 2'b01; WE_I = 2'b00; ADDR_I[0] = 4'd3;
    #1;
    check("midreset_gnt", 32'(GNT_O), 32'd1);
    do_reset(1'b0, 4'd0);
    single(0, 1'b0, 4'd3, 32'd0, 4'd0, 4'd0);
    idle_cycle();

    // Request held through the scrub is granted in the first SERVE cycle
    do_reset(1'b1, 4'd5);
    cycle(2'b10, 2'b00, 4'd0, 4'd5, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    idle_cycle();
    idle_cycle();

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
